usb_rx_packet: RTL
==================

// Module: usb_rx_packet
// PURPOSE
//  USB low/full-speed packet decoder; sits directly downstream of the byte receiver, upstream of the SIE.
//  Consumes the receiver's byte stream (data/active/valid/error), checks the PID, checks CRC5/CRC16 and length,
//  and extracts token fields. Forwards DATA payload with the two CRC16 bytes stripped.
//  Reports one end-of-packet status pulse per packet.
// PARAMETERS
//  MAX_PAYLOAD  64  max DATA payload bytes (excl. PID/CRC); longer packet -> len_error
// PORTS
//  clk          in   1   system clock (24 MHz)
//  reset        in   1   synchronous, active-high reset
//  rx_data      in   8   byte from receiver, LSB = first bit on wire
//  rx_active    in   1   high between SYNC and EOP
//  rx_valid     in   1   one-clk pulse, rx_data valid
//  rx_error     in   1   receiver error (bit-stuff/abort)
//  pid          out  4   PID[3:0] of current packet (types::pid_t)
//  addr         out  7   token address
//  endp         out  4   token endpoint
//  frame        out  11  SOF frame number
//  pl_data      out  8   payload byte
//  pl_valid     out  1   one-clk payload strobe
//  pkt_done     out  1   one-clk end-of-packet pulse
//  pkt_ok       out  1   valid with pkt_done: no error of any kind
//  pid_error    out  1   valid with pkt_done: PID[7:4] != ~PID[3:0] or reserved PID
//  crc_error    out  1   valid with pkt_done: CRC residual mismatch
//  len_error    out  1   valid with pkt_done: wrong byte count or receiver error
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, CRC regs all-ones, byte counter 0.
//  FSM: IDLE -> PID on rx_active rise. PID: first rx_valid latches pid; category picks next state:
//   TOKEN (OUT/IN/SETUP/SOF) -> TOK1 -> TOK2 -> WAIT_EOP; DATA (DATA0/1/2/MDATA) -> DATA;
//   HANDSHAKE/PRE -> WAIT_EOP; bad PID -> DISCARD. Any state with rx_error=1 -> DISCARD (len_error latched).
//   Extra bytes in WAIT_EOP set len_error. rx_active fall in any non-IDLE state -> CHECK.
//   CHECK: 1 clk, drives pkt_done plus flags -> IDLE.
//   DISCARD: ignores bytes; on rx_active fall -> CHECK.
//  Token: byte1 -> addr=b1[6:0], endp[0]=b1[7]; byte2 -> endp[3:1]=b2[2:0], CRC5 = b2[7:3].
//   SOF: frame = {b2[2:0], b1}. CRC5 is computed over all 16 bits (LSB first), init 5'b11111;
//   required residual 5'b01100. Missing token bytes -> len_error.
//  DATA: CRC16 (poly 0x8005, init 16'hFFFF, LSB first) over every byte after PID, CRC bytes included;
//   required residual 16'h800D (standard USB). Two-byte hold FIFO: each byte from the 3rd on pushes
//   out the oldest -> pl_valid pulse 1 clk after that rx_valid. The two bytes left at EOP are the CRC
//   and are never forwarded. Fewer than 2 bytes after PID -> len_error.
//   More than MAX_PAYLOAD+2 bytes -> len_error; forwarding stops.
//  pkt_done asserts exactly 1 clk after the clk at which rx_active is sampled low, and only for
//   packets that produced at least a PID byte. rx_active pulse with no byte -> no pkt_done.
//  pkt_ok = ~(pid_error|crc_error|len_error). CRC is not checked for handshake packets.
//  addr/endp/frame/pid hold until the next PID byte. Flags hold until the next pkt_done.
//  rx_active rise while not IDLE (no EOP seen): abort current packet without pkt_done, restart in PID.
//  Reset mid-packet: immediate return to IDLE; no pkt_done or pl_valid for the partial packet.
//  rx_valid and rx_active fall on same clk: the byte is counted first, then CHECK.
// STRUCTURE
//  Package types: pid_t enum (OUT=4'b0001, IN=4'b1001, SOF=4'b0101, SETUP=4'b1101, DATA0=4'b0011,
//   DATA1=4'b1011, DATA2=4'b0111, MDATA=4'b1111, ACK=4'b0010, NAK=4'b1010, STALL=4'b1110,
//   NYET=4'b0110, PRE=4'b1100); CRC5/CRC16 polys, inits and residuals as localparams.
//  Sub-module usb_crc (param WIDTH 5|16, POLY, INIT): byte-wide LSB-first update, clr/en inputs.
//   Instantiated twice.
// TESTING
//  ACK byte D2 -> pkt_done, pid=2, pkt_ok=1, no pl_valid.
//  SETUP 2D 00 10 -> addr=0, endp=0, pkt_ok=1. Same with byte2=11 -> crc_error=1.
//  DATA0 C3 80 06 00 01 00 00 40 00 DD 94 -> 8 pl_valid: 80 06 00 01 00 00 40 00, pkt_ok=1.
//   Flip DD to DC -> crc_error=1.
//  PID C4 -> pid_error=1, DISCARD, following bytes ignored. DATA1 ZLP 4B 00 00 -> pkt_ok, 0 pl_valid.
//  IN token with rx_error mid-byte2 -> len_error=1, pkt_ok=0. reset mid-DATA -> no pkt_done.
//  DATA0 with MAX_PAYLOAD+1 payload bytes -> len_error=1, exactly MAX_PAYLOAD pl_valid pulses.

Source files
------------

// File: rtl/usb_rx_packet_pkg.sv
// Shared types and constants for the USB low/full-speed packet decoder.
package types;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_DATA2 = 4'b0111,
        PID_MDATA = 4'b1111,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110,
        PID_NYET  = 4'b0110,
        PID_PRE   = 4'b1100
    } pid_t;

    typedef enum logic [1:0] {
        CAT_TOKEN,
        CAT_DATA,
        CAT_HS,
        CAT_BAD
    } pid_cat_t;

    localparam logic [4:0]  CRC5_POLY      = 5'b00101;
    localparam logic [4:0]  CRC5_INIT      = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    function automatic pid_cat_t pid_category(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP:         return CAT_TOKEN;
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:  return CAT_DATA;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET,
            PID_PRE:                                     return CAT_HS;
            default:                                     return CAT_BAD;
        endcase
    endfunction

    // A PID byte carries its own one's complement in the upper nibble.
    function automatic logic pid_byte_ok(input logic [7:0] b);
        return (b[7:4] == ~b[3:0]) && (pid_category(b[3:0]) != CAT_BAD);
    endfunction

endpackage

// File: rtl/usb_rx_packet_crc.sv
// Byte-wide, LSB-first USB CRC register (CRC5 or CRC16 depending on parameters).
module usb_crc #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] crc_q;
    logic [WIDTH-1:0] crc_d;

    function automatic logic [WIDTH-1:0] crc_byte(input logic [WIDTH-1:0] c,
                                                  input logic [7:0]       d);
        logic [WIDTH-1:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ r[WIDTH-1]) begin
                r = {r[WIDTH-2:0], 1'b0} ^ POLY;
            end else begin
                r = {r[WIDTH-2:0], 1'b0};
            end
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = INIT;
        end else if (en) begin
            crc_d = crc_byte(crc_q, data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_rx_packet.sv
// USB low/full-speed packet decoder: PID/CRC/length checks, token field extraction, payload forwarding.
module usb_rx_packet
    import types::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [10:0] frame,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        pid_error,
    output logic        crc_error,
    output logic        len_error
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD + 4);
    localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FWD_END = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(MAX_PAYLOAD + 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_TOK1,
        S_TOK2,
        S_DATA,
        S_WAIT_EOP,
        S_DISCARD,
        S_CHECK
    } state_t;

    state_t           state_q;
    logic             act_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             seen_q;
    logic             pid_bad_q;
    logic             rx_err_q;
    logic [7:0]       hold0_q;
    logic [7:0]       hold1_q;
    logic [3:0]       pid_q;
    logic [6:0]       addr_q;
    logic [3:0]       endp_q;
    logic [10:0]      frame_q;
    logic [7:0]       pl_data_q;
    logic             pl_valid_q;
    logic             pkt_done_q;
    logic             pkt_ok_q;
    logic             pid_error_q;
    logic             crc_error_q;
    logic             len_error_q;

    logic             rx_rise;
    logic             in_pkt;
    logic [CNT_W-1:0] cnt_inc;
    pid_cat_t         rx_cat;
    pid_cat_t         cur_cat;
    logic             crc5_en;
    logic             crc16_en;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic             len_bad;
    logic             crc_bad;

    assign rx_rise  = rx_active & ~act_prev_q;
    assign in_pkt   = (state_q == S_PID) || (state_q == S_TOK1) || (state_q == S_TOK2) ||
                      (state_q == S_DATA) || (state_q == S_WAIT_EOP);
    assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    assign rx_cat   = pid_category(rx_data[3:0]);
    assign cur_cat  = pid_category(pid_q);
    assign crc5_en  = rx_valid & ~rx_error & ((state_q == S_TOK1) || (state_q == S_TOK2));
    assign crc16_en = rx_valid & ~rx_error & (state_q == S_DATA);

    usb_crc #(
        .WIDTH (5),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk   (clk),
        .reset (reset),
        .clr   (rx_rise),
        .en    (crc5_en),
        .data  (rx_data),
        .crc   (crc5)
    );

    usb_crc #(
        .WIDTH (16),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk   (clk),
        .reset (reset),
        .clr   (rx_rise),
        .en    (crc16_en),
        .data  (rx_data),
        .crc   (crc16)
    );

    // Length and CRC verdicts are only meaningful for a good PID with no receiver error.
    always_comb begin
        len_bad = rx_err_q;
        crc_bad = 1'b0;
        if (!pid_bad_q && !rx_err_q) begin
            case (cur_cat)
                CAT_TOKEN: begin
                    len_bad = (cnt_q != CNT_TWO);
                    crc_bad = (crc5 != CRC5_RESIDUAL);
                end
                CAT_DATA: begin
                    len_bad = (cnt_q < CNT_TWO) || (cnt_q > CNT_FWD_END);
                    crc_bad = (crc16 != CRC16_RESIDUAL);
                end
                CAT_HS: begin
                    len_bad = (cnt_q != '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            act_prev_q  <= 1'b0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            pid_bad_q   <= 1'b0;
            rx_err_q    <= 1'b0;
            pid_q       <= '0;
            addr_q      <= '0;
            endp_q      <= '0;
            frame_q     <= '0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_ok_q    <= 1'b0;
            pid_error_q <= 1'b0;
            crc_error_q <= 1'b0;
            len_error_q <= 1'b0;
        end else begin
            act_prev_q <= rx_active;
            pl_valid_q <= 1'b0;
            pkt_done_q <= 1'b0;

            if (in_pkt && rx_error) begin
                rx_err_q <= 1'b1;
                state_q  <= S_DISCARD;
            end else begin
                case (state_q)
                    S_PID: begin
                        if (rx_valid) begin
                            seen_q    <= 1'b1;
                            pid_q     <= rx_data[3:0];
                            pid_bad_q <= ~pid_byte_ok(rx_data);
                            if (!pid_byte_ok(rx_data)) begin
                                state_q <= S_DISCARD;
                            end else begin
                                case (rx_cat)
                                    CAT_TOKEN: state_q <= S_TOK1;
                                    CAT_DATA:  state_q <= S_DATA;
                                    default:   state_q <= S_WAIT_EOP;
                                endcase
                            end
                        end
                        if (!rx_active) begin
                            state_q <= rx_valid ? S_CHECK : S_IDLE;
                        end
                    end
                    S_TOK1: begin
                        if (rx_valid) begin
                            cnt_q     <= cnt_inc;
                            addr_q    <= rx_data[6:0];
                            endp_q[0] <= rx_data[7];
                            state_q   <= S_TOK2;
                        end
                        if (!rx_active) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_TOK2: begin
                        if (rx_valid) begin
                            cnt_q       <= cnt_inc;
                            endp_q[3:1] <= rx_data[2:0];
                            if (pid_q == PID_SOF) begin
                                frame_q <= {rx_data[2:0], endp_q[0], addr_q};
                            end
                            state_q <= S_WAIT_EOP;
                        end
                        if (!rx_active) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            cnt_q <= cnt_inc;
                            // The newest two bytes may be the CRC, so only the older one leaves.
                            if (cnt_q >= CNT_TWO && cnt_q < CNT_FWD_END) begin
                                pl_data_q  <= hold0_q;
                                pl_valid_q <= 1'b1;
                            end
                            hold0_q <= hold1_q;
                            hold1_q <= rx_data;
                        end
                        if (!rx_active) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_WAIT_EOP: begin
                        if (rx_valid) begin
                            cnt_q <= cnt_inc;
                        end
                        if (!rx_active) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_DISCARD: begin
                        if (!rx_active) begin
                            state_q <= seen_q ? S_CHECK : S_IDLE;
                        end
                    end
                    S_CHECK: begin
                        pkt_done_q  <= 1'b1;
                        pid_error_q <= pid_bad_q;
                        len_error_q <= len_bad;
                        crc_error_q <= crc_bad;
                        pkt_ok_q    <= ~(pid_bad_q | len_bad | crc_bad);
                        state_q     <= S_IDLE;
                    end
                    default: ;
                endcase
            end

            // A new SYNC always starts a fresh packet, abandoning one that never saw EOP.
            if (rx_rise) begin
                state_q   <= S_PID;
                cnt_q     <= '0;
                seen_q    <= 1'b0;
                pid_bad_q <= 1'b0;
                rx_err_q  <= 1'b0;
            end
        end
    end

    assign pid       = pid_q;
    assign addr      = addr_q;
    assign endp      = endp_q;
    assign frame     = frame_q;
    assign pl_data   = pl_data_q;
    assign pl_valid  = pl_valid_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_ok    = pkt_ok_q;
    assign pid_error = pid_error_q;
    assign crc_error = crc_error_q;
    assign len_error = len_error_q;

endmodule
